// File: rtl/score_voice_pkg.sv
// rtl/score_voice_pkg.sv - shared constants, sample type and helpers for score_voice
package score_voice_pkg;

  localparam logic [7:0]  ENV_FULL = 8'd255;
  localparam int          DSM_FB   = 256;
  localparam logic [15:0] REST_MIN = 16'd2;

  typedef logic signed [8:0] sample_t;

  // Periods below REST_MIN encode a rest.
  function automatic logic is_tone(input logic [15:0] c);
    return c >= REST_MIN;
  endfunction

endpackage

// File: rtl/dsm1.sv
// rtl/dsm1.sv - first-order delta-sigma modulator, signed 9-bit sample in, 1-bit stream out
module dsm1
  import score_voice_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  sample_t s,
  output logic    dsd
);

  localparam logic [10:0] FB = 11'(DSM_FB);

  logic [9:0]  acc_q, acc_d;
  logic        dsd_q, dsd_d;
  logic [10:0] fb;
  logic [10:0] nxt;

  // Sample magnitude <= 255 bounds the accumulator to 10 bits; 11 bits keep the sign exact.
  always_comb begin
    fb    = dsd_q ? FB : (11'd0 - FB);
    nxt   = {acc_q[9], acc_q} + {{2{s[8]}}, s} - fb;
    acc_d = nxt[9:0];
    dsd_d = ~nxt[10];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      dsd_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dsd_q <= dsd_d;
    end
  end

  assign dsd = dsd_q;

endmodule

// File: rtl/score_voice.sv
// rtl/score_voice.sv - square-wave voice with linear decay envelope (SCORE_VOICE_ENVELOPE_EN) and DSD output
module score_voice
  import score_voice_pkg::*;
#(
  parameter int DECAY_DIV = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cyc,
  input  logic        attack,
  output logic        dsd,
  output logic [7:0]  env,
  output logic        active
);

  if (DECAY_DIV < 2) begin : g_bad_decay_div
    $error("score_voice: DECAY_DIV must be at least 2");
  end

  logic [15:0] ph_q, ph_d;
  logic [7:0]  env_q, env_d;
  logic        active_q, active_d;
  logic        tone;
  logic        sq;
  sample_t     s;

  assign tone = is_tone(cyc);
  assign sq   = ph_q < (cyc >> 1);

  // The >= compare also wraps cleanly when cyc shrinks below the current phase.
  always_comb begin
    ph_d = ph_q + 16'd1;
    if (attack || !tone || (ph_q >= cyc - 16'd1)) begin
      ph_d = '0;
    end
  end

  always_comb begin
    s = '0;
    if (tone) begin
      s = sq ? sample_t'({1'b0, env_q}) : -sample_t'({1'b0, env_q});
    end
  end

`ifdef SCORE_VOICE_ENVELOPE_EN
  localparam logic [15:0] DV_LAST = 16'(DECAY_DIV - 1);

  logic [15:0] dv_q, dv_d;

  always_comb begin
    dv_d  = dv_q + 16'd1;
    env_d = env_q;
    if (attack) begin
      env_d = ENV_FULL;
      dv_d  = '0;
    end else if (dv_q == DV_LAST) begin
      dv_d = '0;
      if (env_q != '0) begin
        env_d = env_q - 8'd1;
      end
    end
  end

  always_comb begin
    active_d = (env_q != '0) && tone;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q <= '0;
    end else begin
      dv_q <= dv_d;
    end
  end
`else
  always_comb begin
    env_d    = ENV_FULL;
    active_d = tone;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= '0;
      env_q    <= '0;
      active_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      env_q    <= env_d;
      active_q <= active_d;
    end
  end

  dsm1 u_dsm1 (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s),
    .dsd   (dsd)
  );

  assign env    = env_q;
  assign active = active_q;

endmodule
